spi_reg_bridge: RTL and testbench

// Downstream of the SPI slave byte receiver. Synchronises its byte-ready strobe and chip select

---
 rtl/spi_reg_bridge.sv | 138 +++++++++++++
 tb/tb_spi_reg_bridge.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// Register bridge behind an SPI slave byte receiver: synchronises byte/CS strobes into sysclk,
// parses {command, data...} frames, writes control registers and reloads the MISO byte for reads.
module spi_reg_bridge #(
  parameter int NUM_RW = 8,
  parameter int NUM_RO = 4,
  parameter logic [7:0] BAD_BYTE = 8'hEE
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  iRxReady,
  input  logic [7:0]            iRx,
  input  logic                  iSPICS,
  output logic                  oTxReady,
  output logic [7:0]            oTx,
  output logic [NUM_RW*8-1:0]   oRegs,
  output logic [NUM_RW-1:0]     oRegWrite,
  input  logic [NUM_RO*8-1:0]   iStatus,
  output logic [7:0]            oErrCount,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CMD   = 2'd1;
  localparam logic [1:0] WDATA = 2'd2;
  localparam logic [1:0] RDATA = 2'd3;

  // Handshake: oTxReady is a one-cycle strobe; oTx is valid on that cycle and held until the
  // next strobe. There is no back-pressure; the slave picks oTx up at its next byte start.

  logic [1:0] state;
  logic [2:0] rdy_sync;
  logic [2:0] cs_sync;
  logic [3:0] addr;
  logic       bad;

  logic       rx_event;
  logic       cs_rise;
  logic       cs_fall;
  logic       wr_hit;
  logic [3:0] rd_addr;
  logic [7:0] rd_byte;
  logic       rd_bad;

  assign rx_event  = rdy_sync[1] & ~rdy_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign wr_hit    = ({1'b0, addr} < 5'(NUM_RW));
  assign dbg_state = state;

  // The command byte itself carries the first read address, so bypass the addr register there.
  assign rd_addr = (state == CMD) ? iRx[3:0] : addr;

  always_comb begin
    rd_byte = BAD_BYTE;
    rd_bad  = 1'b1;
    for (int k = 0; k < NUM_RW; k++) begin
      if (rd_addr == 4'(k)) begin
        rd_byte = oRegs[8*k +: 8];
        rd_bad  = 1'b0;
      end
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (rd_addr == 4'(NUM_RW + k)) begin
        rd_byte = iStatus[8*k +: 8];
        rd_bad  = 1'b0;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= IDLE;
      rdy_sync  <= '0;
      cs_sync   <= '0;
      addr      <= '0;
      bad       <= 1'b0;
      oRegs     <= '0;
      oRegWrite <= '0;
      oTxReady  <= 1'b0;
      oTx       <= '0;
      oErrCount <= '0;
    end else begin
      rdy_sync  <= {rdy_sync[1:0], iRxReady};
      cs_sync   <= {cs_sync[1:0], iSPICS};
      oRegWrite <= '0;
      oTxReady  <= 1'b0;
      // Frame end wins over any byte event landing on the same cycle.
      if (cs_rise) begin
        state <= IDLE;
        if (bad && oErrCount != 8'hFF) oErrCount <= oErrCount + 8'd1;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state <= CMD;
              bad   <= 1'b0;
            end
          end
          CMD: begin
            if (rx_event) begin
              if (iRx[7]) begin
                state <= WDATA;
                addr  <= iRx[3:0];
              end else begin
                state    <= RDATA;
                oTx      <= rd_byte;
                oTxReady <= 1'b1;
                if (rd_bad) bad <= 1'b1;
                addr     <= iRx[3:0] + 4'd1;
              end
            end
          end
          WDATA: begin
            if (rx_event) begin
              for (int k = 0; k < NUM_RW; k++) begin
                if (addr == 4'(k)) begin
                  oRegs[8*k +: 8] <= iRx;
                  oRegWrite[k]    <= 1'b1;
                end
              end
              if (!wr_hit) bad <= 1'b1;
              addr <= addr + 4'd1;
            end
          end
          default: begin
            if (rx_event) begin
              oTx      <= rd_byte;
              oTxReady <= 1'b1;
              if (rd_bad) bad <= 1'b1;
              addr     <= addr + 4'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: register writes, read-back with latency, address wrap,
// held byte-ready, mid-frame reset and error-counter saturation.
module tb_spi_reg_bridge;

  logic        sysclk;
  logic        reset;
  logic        iRxReady;
  logic [7:0]  iRx;
  logic        iSPICS;
  logic        oTxReady;
  logic [7:0]  oTx;
  logic [63:0] oRegs;
  logic [7:0]  oRegWrite;
  logic [31:0] iStatus;
  logic [7:0]  oErrCount;
  logic [1:0]  dbg_state;

  int total;
  int bad;
  int wr_cnt [8];
  logic [7:0] exp_q[$];

  spi_reg_bridge dut (
    .sysclk(sysclk), .reset(reset), .iRxReady(iRxReady), .iRx(iRx), .iSPICS(iSPICS),
    .oTxReady(oTxReady), .oTx(oTx), .oRegs(oRegs), .oRegWrite(oRegWrite),
    .iStatus(iStatus), .oErrCount(oErrCount), .dbg_state(dbg_state)
  );

  // clock / reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitors: write strobe counts and read-back scoreboard
  always @(negedge sysclk) begin
    for (int k = 0; k < 8; k++) if (oRegWrite[k] === 1'b1) wr_cnt[k]++;
    if (oTxReady === 1'b1) begin
      if (exp_q.size() == 0) chk("tx_unexpected", 64'(exp_q.size() + 1), 64'd0);
      else chk("tx_byte", {56'd0, oTx}, {56'd0, exp_q.pop_front()});
    end
  end

  function automatic int wr_total();
    int s = 0;
    for (int k = 0; k < 8; k++) s += wr_cnt[k];
    return s;
  endfunction

  // driver tasks
  task automatic do_reset();
    @(negedge sysclk);
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge sysclk);
    iSPICS = 1'b0;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic cs_high();
    @(negedge sysclk);
    iSPICS = 1'b1;
    repeat (5) @(negedge sysclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge sysclk);
    iRx = b;
    iRxReady = 1'b1;
    repeat (hold) @(negedge sysclk);
    iRxReady = 1'b0;
    repeat (4) @(negedge sysclk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int k = 0; k < 8; k++) wr_cnt[k] = 0;
    reset = 1'b1;
    iRxReady = 1'b0;
    iRx = 8'h00;
    iSPICS = 1'b1;
    iStatus = 32'hC33C5AA5;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);

    // reset state
    chk("rst_regs", oRegs, 64'd0);
    chk("rst_tx", {56'd0, oTx}, 64'd0);
    chk("rst_txready", {63'd0, oTxReady}, 64'd0);
    chk("rst_errcount", {56'd0, oErrCount}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    repeat (5) @(negedge sysclk);

    // T1: write regs 2,3
    cs_low();
    chk("t1_state_cmd", {62'd0, dbg_state}, 64'd1);
    send_byte(8'h82, 4);
    send_byte(8'h40, 4);
    send_byte(8'h41, 4);
    cs_high();
    chk("t1_reg2", {56'd0, oRegs[23:16]}, 64'h40);
    chk("t1_reg3", {56'd0, oRegs[31:24]}, 64'h41);
    chk("t1_wr2_cnt", 64'(wr_cnt[2]), 64'd1);
    chk("t1_wr3_cnt", 64'(wr_cnt[3]), 64'd1);
    chk("t1_wr_total", 64'(wr_total()), 64'd2);
    chk("t1_errcount", {56'd0, oErrCount}, 64'd0);

    // T2: read status 0,1,2 with command-to-strobe latency
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h3C);
    cs_low();
    @(negedge sysclk);
    iRx = 8'h08;
    iRxReady = 1'b1;
    @(negedge sysclk);
    chk("t2_lat1", {63'd0, oTxReady}, 64'd0);
    @(negedge sysclk);
    chk("t2_lat2", {63'd0, oTxReady}, 64'd0);
    @(negedge sysclk);
    chk("t2_lat3_ready", {63'd0, oTxReady}, 64'd1);
    chk("t2_lat3_tx", {56'd0, oTx}, 64'hA5);
    @(negedge sysclk);
    iRxReady = 1'b0;
    repeat (4) @(negedge sysclk);
    send_byte(8'h00, 4);
    chk("t2_tx_after_b1", {56'd0, oTx}, 64'h5A);
    send_byte(8'h00, 4);
    cs_high();
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t2_errcount", {56'd0, oErrCount}, 64'd0);

    // read control regs 3 then 4
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h00);
    cs_low();
    send_byte(8'h03, 4);
    send_byte(8'h00, 4);
    cs_high();
    chk("rd_rw_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("rd_rw_state", {62'd0, dbg_state}, 64'd0);

    // T3: write starting at 14 wraps to 0
    cs_low();
    send_byte(8'h8E, 4);
    send_byte(8'h11, 4);
    send_byte(8'h22, 4);
    send_byte(8'h33, 4);
    cs_high();
    chk("t3_reg0", {56'd0, oRegs[7:0]}, 64'h33);
    chk("t3_regs", oRegs, 64'h0000_0000_4140_0033);
    chk("t3_wr0_cnt", 64'(wr_cnt[0]), 64'd1);
    chk("t3_wr_total", 64'(wr_total()), 64'd3);
    chk("t3_errcount", {56'd0, oErrCount}, 64'd1);

    // T4: byte-ready held high after last byte
    cs_low();
    send_byte(8'h85, 4);
    @(negedge sysclk);
    iRx = 8'h77;
    iRxReady = 1'b1;
    repeat (20) @(negedge sysclk);
    chk("t4_state_wdata", {62'd0, dbg_state}, 64'd2);
    chk("t4_wr5_cnt_held", 64'(wr_cnt[5]), 64'd1);
    cs_high();
    iRxReady = 1'b0;
    repeat (4) @(negedge sysclk);
    chk("t4_reg5", {56'd0, oRegs[47:40]}, 64'h77);
    chk("t4_wr5_cnt", 64'(wr_cnt[5]), 64'd1);
    chk("t4_state_idle", {62'd0, dbg_state}, 64'd0);
    chk("t4_errcount", {56'd0, oErrCount}, 64'd1);

    // T5: reset mid-frame, rest of frame ignored
    cs_low();
    send_byte(8'h81, 4);
    do_reset();
    send_byte(8'h99, 4);
    send_byte(8'h55, 4);
    chk("t5_regs", oRegs, 64'd0);
    chk("t5_wr_total", 64'(wr_total()), 64'd4);
    chk("t5_state", {62'd0, dbg_state}, 64'd0);
    chk("t5_tx", {56'd0, oTx}, 64'd0);
    chk("t5_errcount", {56'd0, oErrCount}, 64'd0);
    cs_high();
    chk("t5_errcount_end", {56'd0, oErrCount}, 64'd0);
    cs_low();
    send_byte(8'h81, 4);
    send_byte(8'h66, 4);
    cs_high();
    chk("t5_new_frame_reg1", oRegs, 64'h0000_0000_0000_6600);
    chk("t5_wr1_cnt", 64'(wr_cnt[1]), 64'd1);

    // T6: unmapped reads saturate the error counter
    iStatus = 32'h1234_5678;
    for (int f = 0; f < 300; f++) begin
      exp_q.push_back(8'hEE);
      cs_low();
      send_byte(8'h0F, 4);
      cs_high();
      if (f == 9) chk("t6_errcount_10", {56'd0, oErrCount}, 64'd10);
      if (f == 254) chk("t6_errcount_255", {56'd0, oErrCount}, 64'hFF);
    end
    chk("t6_errcount_sat", {56'd0, oErrCount}, 64'hFF);
    chk("t6_tx", {56'd0, oTx}, 64'hEE);
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t6_regs_kept", oRegs, 64'h0000_0000_0000_6600);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
